// File: rtl/cve2_pkg.sv
// Shared types and constants for the cve2 sleep controller.
package cve2_pkg;

  // Sleep controller FSM encoding
  typedef enum logic [1:0] {
    StOff   = 2'd0,
    StRun   = 2'd1,
    StHold  = 2'd2,
    StSleep = 2'd3
  } sleep_ctrl_state_e;

  // Legal parameter ranges for cve2_sleep_ctrl
  localparam int unsigned NumWakeSrcMin     = 1;
  localparam int unsigned NumWakeSrcMax     = 16;
  localparam int unsigned IdleHoldCyclesMin = 0;
  localparam int unsigned IdleHoldCyclesMax = 255;
  localparam int unsigned SleepCntWidthMin  = 8;
  localparam int unsigned SleepCntWidthMax  = 64;

  // Width of the idle hold counter, sized for IdleHoldCyclesMax
  localparam int unsigned HoldCntWidth = 8;

endpackage

// File: rtl/cve2_clock_gate.sv
// Latch-based integrated clock gate with scan override.
module cve2_clock_gate (
  input  logic i_clk,
  input  logic i_en,
  input  logic i_test_en,
  output logic o_clk
);

  logic r_en_latch;

  // Capture the enable while the clock is low so o_clk never glitches
  always_latch begin
    if (!i_clk) begin
      r_en_latch = i_en | i_test_en;
    end
  end

  assign o_clk = i_clk & r_en_latch;

endmodule

// File: rtl/cve2_sleep_ctrl.sv
// Core sleep controller: latches fetch enable, sequences RUN/HOLD/SLEEP
// and gates the core clock. Optional sleep cycle counter is built when
// the macro CVE2_SLEEP_CNT_EN is defined; otherwise sleep_cycles_o is 0.
module cve2_sleep_ctrl
  import cve2_pkg::*;
#(
  parameter int unsigned NumWakeSrc     = 4,
  parameter int unsigned IdleHoldCycles = 4,
  parameter int unsigned SleepCntWidth  = 32
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     test_en_i,
  input  logic                     fetch_enable_i,
  input  logic                     core_busy_i,
  input  logic                     irq_pending_i,
  input  logic                     irq_nm_i,
  input  logic                     debug_req_i,
  input  logic [NumWakeSrc-1:0]    wake_i,
  input  logic [NumWakeSrc-1:0]    wake_mask_i,
  input  logic                     sleep_cnt_clr_i,
  output logic                     clk_o,
  output logic                     fetch_enable_o,
  output logic                     core_sleep_o,
  output logic [SleepCntWidth-1:0] sleep_cycles_o
);

  // Value loaded into the hold counter on entering HOLD; the counter then
  // runs down to zero so HOLD lasts exactly IdleHoldCycles cycles.
  localparam logic [HoldCntWidth-1:0] HoldLoad =
      (IdleHoldCycles > 0) ? HoldCntWidth'(IdleHoldCycles - 1) : '0;
  localparam bit HoldEn = (IdleHoldCycles > 0);

  sleep_ctrl_state_e       r_state;
  sleep_ctrl_state_e       w_state_next;
  logic [HoldCntWidth-1:0] r_hold_cnt;
  logic [HoldCntWidth-1:0] w_hold_cnt_next;
  logic                    r_fetch_en;
  logic                    w_wake;
  logic                    w_idle;
  logic                    w_clk_en;

  assign w_wake = debug_req_i | irq_pending_i | irq_nm_i | (|(wake_i & wake_mask_i));
  assign w_idle = ~core_busy_i & ~w_wake;

  // Sticky fetch enable; only reset clears it
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_fetch_en <= 1'b0;
    end else if (fetch_enable_i) begin
      r_fetch_en <= 1'b1;
    end
  end

  assign fetch_enable_o = r_fetch_en;

  // Next-state and hold counter logic
  always_comb begin
    w_state_next    = r_state;
    w_hold_cnt_next = r_hold_cnt;
    unique case (r_state)
      StOff: begin
        if (r_fetch_en) begin
          w_state_next = StRun;
        end
      end
      StRun: begin
        if (w_idle) begin
          if (HoldEn) begin
            w_state_next    = StHold;
            w_hold_cnt_next = HoldLoad;
          end else begin
            w_state_next = StSleep;
          end
        end
      end
      StHold: begin
        // Activity always wins over the countdown
        if (!w_idle) begin
          w_state_next = StRun;
        end else if (r_hold_cnt == '0) begin
          w_state_next = StSleep;
        end else begin
          w_hold_cnt_next = r_hold_cnt - 1'b1;
        end
      end
      StSleep: begin
        if (w_wake || core_busy_i) begin
          w_state_next = StRun;
        end
      end
      default: begin
        w_state_next = StOff;
      end
    endcase
  end

  // FSM state and hold counter registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state    <= StOff;
      r_hold_cnt <= '0;
    end else begin
      r_state    <= w_state_next;
      r_hold_cnt <= w_hold_cnt_next;
    end
  end

  // Wake opens the gate combinationally so the core sees the edge that
  // ends the wake cycle (zero-cycle wake latency).
  always_comb begin
    w_clk_en = (r_state == StRun) || (r_state == StHold) || ((r_state == StSleep) && w_wake);
  end

  assign core_sleep_o = (r_state == StSleep) & ~w_wake;

  cve2_clock_gate u_clock_gate (
    .i_clk     (clk_i),
    .i_en      (w_clk_en),
    .i_test_en (test_en_i),
    .o_clk     (clk_o)
  );

`ifdef CVE2_SLEEP_CNT_EN
  logic [SleepCntWidth-1:0] r_sleep_cnt;

  // Saturating count of cycles spent in SLEEP; clear has priority
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_sleep_cnt <= '0;
    end else if (sleep_cnt_clr_i) begin
      r_sleep_cnt <= '0;
    end else if ((r_state == StSleep) && !(&r_sleep_cnt)) begin
      r_sleep_cnt <= r_sleep_cnt + 1'b1;
    end
  end

  assign sleep_cycles_o = r_sleep_cnt;
`else
  logic w_unused_sleep_cnt_clr;

  assign w_unused_sleep_cnt_clr = sleep_cnt_clr_i;
  assign sleep_cycles_o         = '0;
`endif

endmodule

// File: tb/tb_cve2_sleep_ctrl.sv
// Directed, table-driven bench for cve2_sleep_ctrl (IdleHoldCycles = 4,
// SleepCntWidth = 8). Counter expectations follow CVE2_SLEEP_CNT_EN.
module tb_cve2_sleep_ctrl;

`ifdef CVE2_SLEEP_CNT_EN
  localparam bit CntEn = 1'b1;
`else
  localparam bit CntEn = 1'b0;
`endif

  logic       clk_i = 1'b0;
  logic       rst_ni = 1'b0;
  logic       test_en_i = 1'b0;
  logic       fetch_enable_i = 1'b0;
  logic       core_busy_i = 1'b0;
  logic       irq_pending_i = 1'b0;
  logic       irq_nm_i = 1'b0;
  logic       debug_req_i = 1'b0;
  logic [3:0] wake_i = 4'b0;
  logic [3:0] wake_mask_i = 4'b0;
  logic       sleep_cnt_clr_i = 1'b0;
  logic       clk_o;
  logic       fetch_enable_o;
  logic       core_sleep_o;
  logic [7:0] sleep_cycles_o;

  int total = 0;
  int bad = 0;
  int gate_edges = 0;

  cve2_sleep_ctrl #(
    .NumWakeSrc     (4),
    .IdleHoldCycles (4),
    .SleepCntWidth  (8)
  ) dut (
    .clk_i           (clk_i),
    .rst_ni          (rst_ni),
    .test_en_i       (test_en_i),
    .fetch_enable_i  (fetch_enable_i),
    .core_busy_i     (core_busy_i),
    .irq_pending_i   (irq_pending_i),
    .irq_nm_i        (irq_nm_i),
    .debug_req_i     (debug_req_i),
    .wake_i          (wake_i),
    .wake_mask_i     (wake_mask_i),
    .sleep_cnt_clr_i (sleep_cnt_clr_i),
    .clk_o           (clk_o),
    .fetch_enable_o  (fetch_enable_o),
    .core_sleep_o    (core_sleep_o),
    .sleep_cycles_o  (sleep_cycles_o)
  );

  always #5 clk_i = ~clk_i;

  always @(posedge clk_o) gate_edges++;

  typedef struct {
    logic       fe;
    logic       busy;
    logic       irqp;
    logic       nm;
    logic       dbg;
    logic [3:0] wk;
    logic [3:0] mk;
    logic       clr;
    logic       tst;
    logic       e_fe;
    logic       e_slp;
    logic       e_gate;
    logic [7:0] e_cnt;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mkv(logic fe, logic busy, logic irqp, logic nm, logic dbg,
                               logic [3:0] wk, logic [3:0] mk, logic clr, logic tst,
                               logic e_fe, logic e_slp, logic e_gate, logic [7:0] e_cnt);
    vec_t v;
    v.fe = fe; v.busy = busy; v.irqp = irqp; v.nm = nm; v.dbg = dbg;
    v.wk = wk; v.mk = mk; v.clr = clr; v.tst = tst;
    v.e_fe = e_fe; v.e_slp = e_slp; v.e_gate = e_gate; v.e_cnt = e_cnt;
    return v;
  endfunction

  function automatic logic [7:0] cnt_exp(logic [7:0] v);
    return CntEn ? v : 8'd0;
  endfunction

  task automatic chk(string name, int idx, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s [%0d]: got %0h expected %0h", name, idx, act, exp);
    end
  endtask

  // One cycle: drive at posedge+1, check state outputs before the falling
  // edge, then check the gated clock at the edge that closes this cycle.
  task automatic run_vec(input vec_t v, input int idx);
    fetch_enable_i  = v.fe;
    core_busy_i     = v.busy;
    irq_pending_i   = v.irqp;
    irq_nm_i        = v.nm;
    debug_req_i     = v.dbg;
    wake_i          = v.wk;
    wake_mask_i     = v.mk;
    sleep_cnt_clr_i = v.clr;
    test_en_i       = v.tst;
    #3;
    chk("fetch_enable_o", idx, 64'(fetch_enable_o), 64'(v.e_fe));
    chk("core_sleep_o", idx, 64'(core_sleep_o), 64'(v.e_slp));
    chk("sleep_cycles_o", idx, 64'(sleep_cycles_o), 64'(cnt_exp(v.e_cnt)));
    @(posedge clk_i);
    #1;
    chk("clk_o_gate", idx, 64'(clk_o), 64'(v.e_gate));
  endtask

  initial begin
    // fe busy irqp nm dbg wk mk clr tst | fe_o sleep gate cnt
    for (int i = 0; i < 5; i++) tbl.push_back(mkv(0,0,0,0,0,4'h0,4'h0,0,0, 0,0,0,0));
    tbl.push_back(mkv(1,0,0,0,0,4'h0,4'h0,0,0, 0,0,0,0));     // c5 fetch pulse
    tbl.push_back(mkv(0,0,0,0,0,4'h0,4'h0,0,0, 1,0,0,0));     // c6 flop set, OFF
    tbl.push_back(mkv(0,1,0,0,0,4'h0,4'h0,0,0, 1,0,1,0));     // c7 RUN
    tbl.push_back(mkv(0,1,0,0,0,4'h0,4'h0,0,0, 1,0,1,0));     // c8
    tbl.push_back(mkv(0,0,0,0,0,4'h0,4'h0,0,0, 1,0,1,0));     // c9 idle -> HOLD
    for (int i = 0; i < 4; i++) tbl.push_back(mkv(0,0,0,0,0,4'h0,4'h0,0,0, 1,0,1,0));
    tbl.push_back(mkv(0,0,0,0,0,4'h0,4'h0,0,0, 1,1,0,0));     // c14 SLEEP
    tbl.push_back(mkv(0,0,0,0,0,4'h4,4'h0,0,0, 1,1,0,1));     // c15 masked wake
    tbl.push_back(mkv(0,0,0,0,0,4'h4,4'h4,0,0, 1,0,1,2));     // c16 enabled wake
    tbl.push_back(mkv(0,0,0,0,0,4'h0,4'h0,0,0, 1,0,1,3));     // c17 RUN
    tbl.push_back(mkv(0,0,0,0,0,4'h0,4'h0,0,0, 1,0,1,3));     // c18 HOLD cnt3
    tbl.push_back(mkv(0,0,0,1,0,4'h0,4'h0,0,0, 1,0,1,3));     // c19 HOLD cnt2, NMI
    tbl.push_back(mkv(0,0,0,0,0,4'h0,4'h0,0,0, 1,0,1,3));     // c20 RUN
    for (int i = 0; i < 4; i++) tbl.push_back(mkv(0,0,0,0,0,4'h0,4'h0,0,0, 1,0,1,3));
    tbl.push_back(mkv(0,0,0,0,0,4'h0,4'h0,0,0, 1,1,0,3));     // c25 SLEEP
    tbl.push_back(mkv(0,1,0,0,0,4'h0,4'h0,0,0, 1,1,0,4));     // c26 busy, gate shut
    tbl.push_back(mkv(0,0,0,0,0,4'h0,4'h0,0,0, 1,0,1,5));     // c27 RUN
    tbl.push_back(mkv(0,0,0,0,1,4'h0,4'h0,0,0, 1,0,1,5));     // c28 HOLD, debug
    tbl.push_back(mkv(0,0,1,0,0,4'h0,4'h0,0,0, 1,0,1,5));     // c29 RUN, irq keeps RUN
    tbl.push_back(mkv(0,0,0,0,0,4'h0,4'h0,0,0, 1,0,1,5));     // c30 RUN -> HOLD
    for (int i = 0; i < 4; i++) tbl.push_back(mkv(0,0,0,0,0,4'h0,4'h0,0,0, 1,0,1,5));
    tbl.push_back(mkv(0,0,0,0,0,4'h0,4'h0,0,1, 1,1,1,5));     // c35 SLEEP, scan
    tbl.push_back(mkv(0,0,0,0,0,4'h0,4'h0,1,0, 1,1,0,6));     // c36 clear
    tbl.push_back(mkv(0,0,0,0,0,4'h0,4'h0,0,0, 1,1,0,0));     // c37
    tbl.push_back(mkv(0,0,0,0,0,4'h0,4'h0,0,0, 1,1,0,1));     // c38

    // Reset state
    repeat (3) @(posedge clk_i);
    #1;
    chk("rst_fetch_enable_o", 0, 64'(fetch_enable_o), 64'd0);
    chk("rst_core_sleep_o", 0, 64'(core_sleep_o), 64'd0);
    chk("rst_sleep_cycles_o", 0, 64'(sleep_cycles_o), 64'd0);
    chk("rst_clk_o", 0, 64'(clk_o), 64'd0);
    rst_ni = 1'b1;

    foreach (tbl[i]) run_vec(tbl[i], i);

    // Long sleep: counter saturates, gate stays closed
    gate_edges = 0;
    for (int i = 0; i < 300; i++) begin
      @(posedge clk_i);
      #1;
    end
    chk("sat_sleep_cycles_o", 300, 64'(sleep_cycles_o), 64'(cnt_exp(8'hFF)));
    chk("sat_core_sleep_o", 300, 64'(core_sleep_o), 64'd1);
    chk("sat_gate_edges", 300, 64'(gate_edges), 64'd0);

    // Asynchronous reset during SLEEP with scan enable
    test_en_i = 1'b1;
    #1;
    rst_ni = 1'b0;
    #1;
    chk("arst_fetch_enable_o", 0, 64'(fetch_enable_o), 64'd0);
    chk("arst_core_sleep_o", 0, 64'(core_sleep_o), 64'd0);
    chk("arst_sleep_cycles_o", 0, 64'(sleep_cycles_o), 64'd0);
    gate_edges = 0;
    repeat (4) @(posedge clk_i);
    #1;
    chk("arst_scan_edges", 0, 64'(gate_edges), 64'd4);
    test_en_i = 1'b0;
    gate_edges = 0;
    repeat (3) @(posedge clk_i);
    #1;
    chk("arst_noscan_edges", 0, 64'(gate_edges), 64'd0);
    rst_ni = 1'b1;

    // Restart from OFF: nothing retained, fetch must be requested again
    run_vec(mkv(0,0,0,0,0,4'h0,4'h0,0,0, 0,0,0,0), 100);
    run_vec(mkv(0,0,0,0,0,4'h0,4'h0,0,0, 0,0,0,0), 101);
    run_vec(mkv(1,0,0,0,0,4'h0,4'h0,0,0, 0,0,0,0), 102);
    run_vec(mkv(0,0,0,0,0,4'h0,4'h0,0,0, 1,0,0,0), 103);
    run_vec(mkv(0,1,0,0,0,4'h0,4'h0,0,0, 1,0,1,0), 104);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
